instruction_fetch_mem: RTL and testbench

- Parametrised instruction memory for the fetch stage. Replaces the fixed 16-bit, single-cycle instruction memory.
- Generalised in four ways: configurable instruction width, depth and read latency; a flush input that kills in-flight fetches; misalignment/out-of-range fault detection; a returned PC tag.
- Sits between the PC register and the decode stage. Supports program loading through a write port, and freezes its whole read pipeline on hazard stall.

---
 rtl/instruction_fetch_mem.sv | 106 ++++++++++
 tb/tb_instruction_fetch_mem.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch_mem.sv
// instruction_fetch_mem: parametrised instruction memory for the fetch stage.
// A synchronous RAM read feeds a LATENCY-deep pipeline. Each stage carries
// {valid, pc, fault, instr}, and the last stage drives the outputs directly.
// Ports:
//   clk_i, reset_n_i         clock and async active-low reset
//   prog_we_i/addr_i/data_i  program-load write port (byte address)
//   fetch_valid_i/addr_i     fetch request (byte address = PC)
//   stall_i                  freezes every stage; flush_i kills in-flight fetches
//   valid_o, instr_o, pc_o, fault_o  fetch result from the last stage
module instruction_fetch_mem #(
  parameter int unsigned INSTR_W   = 16,
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DEPTH     = 1024,
  parameter int unsigned LATENCY   = 1,
  parameter logic [15:0] NOP_INSTR = 16'hBF00
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               prog_we_i,
  input  logic [ADDR_W-1:0]  prog_addr_i,
  input  logic [INSTR_W-1:0] prog_data_i,
  input  logic               fetch_valid_i,
  input  logic [ADDR_W-1:0]  fetch_addr_i,
  input  logic               stall_i,
  input  logic               flush_i,
  output logic               valid_o,
  output logic [INSTR_W-1:0] instr_o,
  output logic [ADDR_W-1:0]  pc_o,
  output logic               fault_o
);

  localparam int unsigned BYTES    = INSTR_W / 8;
  localparam int unsigned OFF_W    = $clog2(BYTES);
  localparam int unsigned IDX_W    = $clog2(DEPTH);
  localparam int unsigned HI_SHIFT = OFF_W + IDX_W;

  typedef struct packed {
    logic               valid;
    logic [ADDR_W-1:0]  pc;
    logic               fault;
    logic [INSTR_W-1:0] instr;
  } stage_t;

  logic [INSTR_W-1:0] mem [DEPTH];
  stage_t             pipe [LATENCY];

  logic               fetch_bad;
  logic               prog_bad;
  logic               accept;
  logic [IDX_W-1:0]   fetch_idx;
  logic [IDX_W-1:0]   prog_idx;

  // Misaligned if any sub-word offset bit is set; out of range if any bit
  // above the word index is set (word index >= DEPTH).
  function automatic logic addr_bad(input logic [ADDR_W-1:0] a);
    return (a[OFF_W-1:0] != '0) || ((a >> HI_SHIFT) != '0);
  endfunction

  // Address decode for both ports
  always_comb begin
    fetch_bad = addr_bad(fetch_addr_i);
    prog_bad  = addr_bad(prog_addr_i);
    fetch_idx = IDX_W'(fetch_addr_i >> OFF_W);
    prog_idx  = IDX_W'(prog_addr_i >> OFF_W);
    // Program mode turns the fetch slot into a bubble, which also rules out
    // a same-cycle read of the word being written.
    accept    = fetch_valid_i && !prog_we_i && !stall_i && !flush_i;
  end

  // Program-load write port; contents are not reset, and stall/flush do not gate it
  always_ff @(posedge clk_i) begin
    if (prog_we_i && !prog_bad) begin
      mem[prog_idx] <= prog_data_i;
    end
  end

  // Fetch pipeline: flush beats stall, and stall holds every field
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      for (int i = 0; i < LATENCY; i++) begin
        pipe[i] <= '0;
      end
    end else if (flush_i) begin
      for (int i = 0; i < LATENCY; i++) begin
        pipe[i].valid <= 1'b0;
      end
    end else if (!stall_i) begin
      pipe[0].valid <= accept;
      // Payload only moves on an accepted fetch; bubbles leave it stale
      if (accept) begin
        pipe[0].pc    <= fetch_addr_i;
        pipe[0].fault <= fetch_bad;
        pipe[0].instr <= fetch_bad ? INSTR_W'(NOP_INSTR) : mem[fetch_idx];
      end
      for (int i = 1; i < LATENCY; i++) begin
        pipe[i] <= pipe[i-1];
      end
    end
  end

  assign valid_o = pipe[LATENCY-1].valid;
  assign instr_o = pipe[LATENCY-1].instr;
  assign pc_o    = pipe[LATENCY-1].pc;
  assign fault_o = pipe[LATENCY-1].fault;

endmodule

// File: tb/tb_instruction_fetch_mem.sv
// Directed bench for instruction_fetch_mem. Two instances share the same
// inputs: u_l1 uses LATENCY=1 and u_l2 uses LATENCY=2.
module tb_instruction_fetch_mem;

  logic        clk;
  logic        rst_n;
  logic        prog_we;
  logic [31:0] prog_addr;
  logic [15:0] prog_data;
  logic        fetch_valid;
  logic [31:0] fetch_addr;
  logic        stall;
  logic        flush;

  logic        v1, f1, v2, f2;
  logic [15:0] i1, i2;
  logic [31:0] pc1, pc2;

  int passed = 0;
  int total  = 0;

  instruction_fetch_mem #(.INSTR_W(16), .ADDR_W(32), .DEPTH(1024), .LATENCY(1)) u_l1 (
    .clk_i(clk), .reset_n_i(rst_n), .prog_we_i(prog_we), .prog_addr_i(prog_addr),
    .prog_data_i(prog_data), .fetch_valid_i(fetch_valid), .fetch_addr_i(fetch_addr),
    .stall_i(stall), .flush_i(flush), .valid_o(v1), .instr_o(i1), .pc_o(pc1), .fault_o(f1)
  );

  instruction_fetch_mem #(.INSTR_W(16), .ADDR_W(32), .DEPTH(1024), .LATENCY(2)) u_l2 (
    .clk_i(clk), .reset_n_i(rst_n), .prog_we_i(prog_we), .prog_addr_i(prog_addr),
    .prog_data_i(prog_data), .fetch_valid_i(fetch_valid), .fetch_addr_i(fetch_addr),
    .stall_i(stall), .flush_i(flush), .valid_o(v2), .instr_o(i2), .pc_o(pc2), .fault_o(f2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle just after it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    prog_we = 1'b0; fetch_valid = 1'b0; stall = 1'b0; flush = 1'b0;
  endtask

  task automatic write_word(input logic [31:0] a, input logic [15:0] d);
    prog_we = 1'b1; prog_addr = a; prog_data = d;
    tick();
    prog_we = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b1; idle(); prog_addr = '0; prog_data = '0; fetch_addr = '0;
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({v1, f1, pc1, i1} !== 50'h0) $display("FAIL reset_l1: got %h exp 0", {v1, f1, pc1, i1});
    else passed++;
    total++;
    if ({v2, f2, pc2, i2} !== 50'h0) $display("FAIL reset_l2: got %h exp 0", {v2, f2, pc2, i2});
    else passed++;
    tick(); tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic load_program();
    write_word(32'h0,  16'h1111);
    write_word(32'h2,  16'h2222);
    write_word(32'h4,  16'h4444);
    write_word(32'h10, 16'h1234);
    write_word(32'h12, 16'hABCD);
    write_word(32'h20, 16'h2020);
  endtask

  task automatic test_load_read();
    fetch_valid = 1'b1; fetch_addr = 32'h10;
    tick();
    total++;
    if ({v1, f1, pc1, i1} !== {1'b1, 1'b0, 32'h10, 16'h1234})
      $display("FAIL load_a_l1: got %h exp %h", {v1, f1, pc1, i1}, {1'b1, 1'b0, 32'h10, 16'h1234});
    else passed++;
    total++;
    if (v2 !== 1'b0) $display("FAIL load_a_l2_latency: got valid %b exp 0", v2);
    else passed++;
    fetch_addr = 32'h12;
    tick();
    total++;
    if ({v1, f1, pc1, i1} !== {1'b1, 1'b0, 32'h12, 16'hABCD})
      $display("FAIL load_b_l1: got %h exp %h", {v1, f1, pc1, i1}, {1'b1, 1'b0, 32'h12, 16'hABCD});
    else passed++;
    total++;
    if ({v2, f2, pc2, i2} !== {1'b1, 1'b0, 32'h10, 16'h1234})
      $display("FAIL load_a_l2: got %h exp %h", {v2, f2, pc2, i2}, {1'b1, 1'b0, 32'h10, 16'h1234});
    else passed++;
    fetch_valid = 1'b0;
    tick();
    total++;
    if (v1 !== 1'b0) $display("FAIL load_drain_l1: got valid %b exp 0", v1);
    else passed++;
    tick(); tick();
  endtask

  task automatic test_stall();
    fetch_valid = 1'b1; fetch_addr = 32'h0;
    tick();
    fetch_addr = 32'h2;
    tick();
    total++;
    if ({v2, f2, pc2, i2} !== {1'b1, 1'b0, 32'h0, 16'h1111})
      $display("FAIL stall_pre: got %h exp %h", {v2, f2, pc2, i2}, {1'b1, 1'b0, 32'h0, 16'h1111});
    else passed++;
    stall = 1'b1; fetch_addr = 32'h4;
    prog_we = 1'b1; prog_addr = 32'h2; prog_data = 16'hFFFF;
    for (int c = 0; c < 3; c++) begin
      tick();
      prog_we = 1'b0;
      total++;
      if ({v2, f2, pc2, i2} !== {1'b1, 1'b0, 32'h0, 16'h1111})
        $display("FAIL stall_hold_%0d: got %h exp %h", c, {v2, f2, pc2, i2}, {1'b1, 1'b0, 32'h0, 16'h1111});
      else passed++;
    end
    stall = 1'b0;
    tick();
    total++;
    if ({v2, f2, pc2, i2} !== {1'b1, 1'b0, 32'h2, 16'h2222})
      $display("FAIL stall_release_2: got %h exp %h", {v2, f2, pc2, i2}, {1'b1, 1'b0, 32'h2, 16'h2222});
    else passed++;
    fetch_valid = 1'b0;
    tick();
    total++;
    if ({v2, f2, pc2, i2} !== {1'b1, 1'b0, 32'h4, 16'h4444})
      $display("FAIL stall_release_4: got %h exp %h", {v2, f2, pc2, i2}, {1'b1, 1'b0, 32'h4, 16'h4444});
    else passed++;
    tick();
    total++;
    if (v2 !== 1'b0) $display("FAIL stall_drain: got valid %b exp 0", v2);
    else passed++;
    tick();
  endtask

  task automatic test_flush();
    fetch_valid = 1'b1; fetch_addr = 32'h0;
    tick();
    fetch_addr = 32'h4;
    tick();
    fetch_valid = 1'b0; stall = 1'b1; flush = 1'b1;
    tick();
    total++;
    if ({v1, v2} !== 2'b00) $display("FAIL flush_kill: got valid l1/l2 %b exp 00", {v1, v2});
    else passed++;
    stall = 1'b0; flush = 1'b0; fetch_valid = 1'b1; fetch_addr = 32'h20;
    tick();
    total++;
    if (v2 !== 1'b0) $display("FAIL flush_stale_l2: got valid %b exp 0", v2);
    else passed++;
    total++;
    if ({v1, f1, pc1, i1} !== {1'b1, 1'b0, 32'h20, 16'h2020})
      $display("FAIL flush_next_l1: got %h exp %h", {v1, f1, pc1, i1}, {1'b1, 1'b0, 32'h20, 16'h2020});
    else passed++;
    fetch_valid = 1'b0;
    tick();
    total++;
    if ({v2, f2, pc2, i2} !== {1'b1, 1'b0, 32'h20, 16'h2020})
      $display("FAIL flush_next_l2: got %h exp %h", {v2, f2, pc2, i2}, {1'b1, 1'b0, 32'h20, 16'h2020});
    else passed++;
    tick(); tick();
  endtask

  task automatic test_faults();
    fetch_valid = 1'b1; fetch_addr = 32'h3;
    tick();
    total++;
    if ({v1, f1, pc1, i1} !== {1'b1, 1'b1, 32'h3, 16'hBF00})
      $display("FAIL fault_misalign_l1: got %h exp %h", {v1, f1, pc1, i1}, {1'b1, 1'b1, 32'h3, 16'hBF00});
    else passed++;
    fetch_addr = 32'h800;
    tick();
    total++;
    if ({v1, f1, pc1, i1} !== {1'b1, 1'b1, 32'h800, 16'hBF00})
      $display("FAIL fault_range_l1: got %h exp %h", {v1, f1, pc1, i1}, {1'b1, 1'b1, 32'h800, 16'hBF00});
    else passed++;
    total++;
    if ({v2, f2, pc2, i2} !== {1'b1, 1'b1, 32'h3, 16'hBF00})
      $display("FAIL fault_misalign_l2: got %h exp %h", {v2, f2, pc2, i2}, {1'b1, 1'b1, 32'h3, 16'hBF00});
    else passed++;
    fetch_addr = 32'h7FE;
    tick();
    total++;
    if ({v1, f1, pc1} !== {1'b1, 1'b0, 32'h7FE})
      $display("FAIL fault_last_word_l1: got %h exp %h", {v1, f1, pc1}, {1'b1, 1'b0, 32'h7FE});
    else passed++;
    total++;
    if ({v2, f2, pc2, i2} !== {1'b1, 1'b1, 32'h800, 16'hBF00})
      $display("FAIL fault_range_l2: got %h exp %h", {v2, f2, pc2, i2}, {1'b1, 1'b1, 32'h800, 16'hBF00});
    else passed++;
    fetch_valid = 1'b0;
    tick(); tick(); tick();
  endtask

  task automatic test_bubble();
    fetch_valid = 1'b1; fetch_addr = 32'h0;
    prog_we = 1'b1; prog_addr = 32'h0; prog_data = 16'h5A5A;
    tick();
    total++;
    if (v1 !== 1'b0) $display("FAIL bubble_1_l1: got valid %b exp 0", v1);
    else passed++;
    tick();
    total++;
    if ({v1, v2} !== 2'b00) $display("FAIL bubble_2: got valid l1/l2 %b exp 00", {v1, v2});
    else passed++;
    prog_we = 1'b0;
    tick();
    total++;
    if ({v1, f1, pc1, i1} !== {1'b1, 1'b0, 32'h0, 16'h5A5A})
      $display("FAIL bubble_after_l1: got %h exp %h", {v1, f1, pc1, i1}, {1'b1, 1'b0, 32'h0, 16'h5A5A});
    else passed++;
    total++;
    if (v2 !== 1'b0) $display("FAIL bubble_tail_l2: got valid %b exp 0", v2);
    else passed++;
    fetch_addr = 32'h2;
    tick();
    total++;
    if ({v1, f1, pc1, i1} !== {1'b1, 1'b0, 32'h2, 16'hFFFF})
      $display("FAIL stall_write_landed: got %h exp %h", {v1, f1, pc1, i1}, {1'b1, 1'b0, 32'h2, 16'hFFFF});
    else passed++;
    fetch_valid = 1'b0;
    tick(); tick();
  endtask

  task automatic test_async_reset();
    fetch_valid = 1'b1; fetch_addr = 32'h4;
    tick(); tick();
    total++;
    if ({v1, v2} !== 2'b11) $display("FAIL arst_pre: got valid l1/l2 %b exp 11", {v1, v2});
    else passed++;
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({v1, f1, pc1, i1} !== 50'h0) $display("FAIL arst_l1: got %h exp 0", {v1, f1, pc1, i1});
    else passed++;
    total++;
    if ({v2, f2, pc2, i2} !== 50'h0) $display("FAIL arst_l2: got %h exp 0", {v2, f2, pc2, i2});
    else passed++;
    fetch_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    fetch_valid = 1'b1; fetch_addr = 32'h0;
    tick();
    total++;
    if ({v1, f1, pc1, i1} !== {1'b1, 1'b0, 32'h0, 16'h5A5A})
      $display("FAIL arst_mem_l1: got %h exp %h", {v1, f1, pc1, i1}, {1'b1, 1'b0, 32'h0, 16'h5A5A});
    else passed++;
    total++;
    if (v2 !== 1'b0) $display("FAIL arst_first_l2: got valid %b exp 0", v2);
    else passed++;
    fetch_valid = 1'b0;
    tick();
    total++;
    if ({v2, f2, pc2, i2} !== {1'b1, 1'b0, 32'h0, 16'h5A5A})
      $display("FAIL arst_mem_l2: got %h exp %h", {v2, f2, pc2, i2}, {1'b1, 1'b0, 32'h0, 16'h5A5A});
    else passed++;
    tick();
  endtask

  initial begin
    test_reset();
    load_program();
    test_load_read();
    test_stall();
    test_flush();
    test_faults();
    test_bubble();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
